// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder constants: coefficient/sample widths, quant table, zig-zag LUT.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package jpeg_dec_pkg;

  localparam int COEF_W = 12;
  localparam int OUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } rd_state_e;

  // One dequantized coefficient on its way into a bank
  typedef struct packed {
    logic             last;
    logic             eof;
    logic             bank;
    logic [5:0]       addr;
    logic [OUT_W-1:0] dat;
  } wr_req_t;

  // Quant table in zig-zag order (luma base table, highest frequency set to full scale)
  localparam logic [7:0] Q_TABLE [64] = '{
    8'd16,  8'd11,  8'd12,  8'd14,  8'd12,  8'd10,  8'd16,  8'd14,
    8'd13,  8'd14,  8'd18,  8'd17,  8'd16,  8'd19,  8'd24,  8'd40,
    8'd26,  8'd24,  8'd22,  8'd22,  8'd24,  8'd49,  8'd35,  8'd37,
    8'd29,  8'd40,  8'd58,  8'd51,  8'd61,  8'd60,  8'd57,  8'd51,
    8'd56,  8'd55,  8'd64,  8'd72,  8'd92,  8'd78,  8'd64,  8'd68,
    8'd87,  8'd69,  8'd55,  8'd56,  8'd80,  8'd109, 8'd81,  8'd87,
    8'd95,  8'd98,  8'd103, 8'd104, 8'd103, 8'd62,  8'd77,  8'd113,
    8'd121, 8'd112, 8'd100, 8'd120, 8'd92,  8'd101, 8'd103, 8'd255
  };

  // Zig-zag index -> raster position
  localparam logic [5:0] UNZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dequant_bank_ram.sv
// Two 64x16 sample banks: one write port, one registered read port.
// Latency: read data valid one cycle after rd_en_i.
// Backpressure: none; rd_dat_o holds while rd_en_i is low.
module dequant_bank_ram
  import jpeg_dec_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [6:0]       wr_addr_i,
  input  logic [OUT_W-1:0] wr_dat_i,
  input  logic             rd_en_i,
  input  logic [6:0]       rd_addr_i,
  output logic [OUT_W-1:0] rd_dat_o
);

  logic [OUT_W-1:0] mem_q [128];
  logic [OUT_W-1:0] rd_dat_q;

  // Storage array; contents are qualified by the written-masks, so no reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
  end

  // Registered read port, holds its value when not enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_dat_q <= '0;
    else if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/dequant_unzigzag.sv
// Dequantizes zig-zag coefficients into ping-pong banks and streams 8x8 blocks in raster order.
// Latency: 3 cycles from accepted last coefficient to first out_valid; one LOAD bubble between blocks.
// Backpressure: coef_ready drops while the write bank is full/being read; d_out holds while out_ready is low.
// Build option DEQUANT_SAT_EN: saturate products to 16 bits (default wraps to the low 16 bits).
module dequant_unzigzag
  import jpeg_dec_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst,
  input  logic [1:0]        factor_sel,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_d,
  input  logic              coef_last,
  input  logic              eof_in,
  output logic              coef_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  d_out,
  output logic              eof_out
);

  // write side
  logic             init_q;
  logic [5:0]       wr_idx_q;
  logic             wr_bank_q;
  logic [1:0]       fs_q;
  logic             s1_vld_q;
  wr_req_t          s1_q;
  logic             acc;
  logic             blk_end;
  logic [1:0]       fs_cur;
  logic [10:0]      q_sh;
  logic [OUT_W-1:0] dq;

  // bank bookkeeping
  logic [1:0][63:0] mask_q;
  logic [1:0]       full_q;
  logic [1:0]       eof_flag_q;

  // read side
  rd_state_e        state_q, state_d;
  logic [5:0]       rd_addr_q, rd_addr_d;
  logic             rd_bank_q, rd_bank_d;
  logic             hit_q;
  logic             rd_en;
  logic             rd_free;
  logic [OUT_W-1:0] ram_dat;

  assign coef_ready = init_q & ~full_q[wr_bank_q];
  assign acc        = coef_valid & coef_ready;
  assign blk_end    = coef_last | (wr_idx_q == 6'd63);
  // the scale is taken from the port on the first coefficient and held for the rest of the block
  assign fs_cur     = (wr_idx_q == 6'd0) ? factor_sel : fs_q;
  assign q_sh       = {3'b000, Q_TABLE[wr_idx_q]} << fs_cur;

`ifdef DEQUANT_SAT_EN
  // full-range product: 12b signed coefficient times up to 2040
  logic signed [23:0] prod_wide;
  assign prod_wide = $signed({{12{coef_d[COEF_W-1]}}, coef_d}) * $signed({13'b0, q_sh});

  // Clamp the product to the signed 16-bit sample range
  always_comb begin
    if (prod_wide > 24'sd32767)       dq = 16'h7FFF;
    else if (prod_wide < -24'sd32768) dq = 16'h8000;
    else                              dq = prod_wide[OUT_W-1:0];
  end
`else
  // only the low 16 bits survive, so a 16-bit multiply gives them directly
  logic [OUT_W-1:0] coef_ext;
  logic [OUT_W-1:0] q_ext;
  assign coef_ext = {{(OUT_W-COEF_W){coef_d[COEF_W-1]}}, coef_d};
  assign q_ext    = {{(OUT_W-11){1'b0}}, q_sh};
  assign dq       = coef_ext * q_ext;
`endif

  // Accept coefficients: zig-zag index, target bank, block scale, product register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      init_q    <= 1'b0;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      fs_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
    end else begin
      init_q   <= 1'b1;
      s1_vld_q <= acc;
      if (acc) begin
        s1_q.dat  <= dq;
        s1_q.addr <= UNZZ[wr_idx_q];
        s1_q.bank <= wr_bank_q;
        s1_q.last <= blk_end;
        s1_q.eof  <= eof_in & blk_end;
        fs_q      <= fs_cur;
        if (blk_end) begin
          wr_idx_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_idx_q <= wr_idx_q + 6'd1;
        end
      end
    end
  end

  // Bank flags: mask clear on first coefficient, mask set per write, full on last write, free after streaming
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      mask_q     <= '0;
      full_q     <= '0;
      eof_flag_q <= '0;
    end else begin
      if (acc && (wr_idx_q == 6'd0)) mask_q[wr_bank_q] <= '0;
      if (s1_vld_q) mask_q[s1_q.bank][s1_q.addr] <= 1'b1;
      if (rd_free) full_q[rd_bank_q] <= 1'b0;
      if (s1_vld_q && s1_q.last) begin
        full_q[s1_q.bank]     <= 1'b1;
        eof_flag_q[s1_q.bank] <= s1_q.eof;
      end
    end
  end

  dequant_bank_ram u_ram (
    .clk_i     (clk_in),
    .rst_ni    (rst),
    .wr_en_i   (s1_vld_q),
    .wr_addr_i ({s1_q.bank, s1_q.addr}),
    .wr_dat_i  (s1_q.dat),
    .rd_en_i   (rd_en),
    .rd_addr_i ({rd_bank_q, rd_addr_d}),
    .rd_dat_o  (ram_dat)
  );

  // Read sequencer: LOAD primes the registered read, STREAM walks the raster addresses
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_free   = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = LOAD;
      end
      LOAD: begin
        rd_en     = 1'b1;
        rd_addr_d = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (rd_addr_q == 6'd63) begin
            rd_free   = 1'b1;
            rd_bank_d = ~rd_bank_q;
            state_d   = full_q[~rd_bank_q] ? LOAD : IDLE;
          end else begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read state registers; the mask bit travels alongside the RAM read data
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
      if (rd_en) hit_q <= mask_q[rd_bank_q][rd_addr_d];
    end
  end

  assign out_valid = (state_q == STREAM);
  assign d_out     = (out_valid && hit_q) ? ram_dat : '0;
  assign eof_out   = out_valid && (rd_addr_q == 6'd63) && eof_flag_q[rd_bank_q];

endmodule

// File: tb/tb_dequant_unzigzag.sv
// Scoreboard bench for dequant_unzigzag: blocks are modelled as they are driven,
// expected raster samples queued, and popped as the DUT hands samples downstream.
`timescale 1ns/1ps
module tb_dequant_unzigzag;
  import jpeg_dec_pkg::*;

  typedef struct packed {
    logic [15:0] dat;
    logic        eof;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  factor_sel = 2'd0;
  logic        coef_valid = 1'b0;
  logic [11:0] coef_d = 12'd0;
  logic        coef_last = 1'b0;
  logic        eof_in = 1'b0;
  logic        coef_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] d_out;
  logic        eof_out;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          zz[64];
  int          blk_coef[64];
  int          rdy_mode = 0;
  int          acc_cnt = 0;
  int          eof_cnt = 0;
  int          eof_bad = 0;
  bit          held = 1'b0;
  logic [15:0] held_dat;

  dequant_unzigzag dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .factor_sel (factor_sel),
    .coef_valid (coef_valid),
    .coef_d     (coef_d),
    .coef_last  (coef_last),
    .eof_in     (eof_in),
    .coef_ready (coef_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d_out      (d_out),
    .eof_out    (eof_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // zig-zag walk: even anti-diagonals run bottom-left to top-right, odd ones the other way
  function automatic void build_zz();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic logic [15:0] dq_model(input int c, input int q, input int fs);
    int p;
    logic [31:0] pv;
    p = c * (q << fs);
`ifdef DEQUANT_SAT_EN
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
`endif
    pv = p;
    return pv[15:0];
  endfunction

  // model the block into the scoreboard, then drive its n coefficients
  task automatic send_block(input int n, input int fs, input bit eof, input bit gaps);
    logic [15:0] img [64];
    exp_t e;
    int wc;
    bit took;
    bit tmo;
    logic [1:0] fs2;
    int cv;
    fs2 = fs[1:0];
    for (int i = 0; i < 64; i++) img[i] = 16'h0;
    for (int k = 0; k < n; k++) img[zz[k]] = dq_model(blk_coef[k], int'(Q_TABLE[k]), fs);
    for (int i = 0; i < 64; i++) begin
      e.dat = img[i];
      e.eof = eof && (i == 63);
      exp_q.push_back(e);
    end
    tmo = 1'b0;
    for (int k = 0; k < n && !tmo; k++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        coef_valid = 1'b0;
        tick(1);
      end
      cv = blk_coef[k];
      coef_valid = 1'b1;
      coef_d     = cv[11:0];
      coef_last  = (k == n - 1) && (n < 64);
      eof_in     = (k == n - 1) && eof;
      factor_sel = (k == 0) ? fs2 : 2'($urandom_range(0, 3));
      wc = 0;
      forever begin
        took = coef_ready;
        tick(1);
        if (took) break;
        wc++;
        if (wc > 3000) begin
          check_val("coef_accept_timeout", 32'd0, 32'd1);
          tmo = 1'b1;
          break;
        end
      end
    end
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    eof_in     = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin tick(1); c++; end
    check_val("drain_left", exp_q.size(), 0);
  endtask

  // downstream ready pattern
  always @(posedge clk_in) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: compare accepted samples, check stability while stalled
  always @(negedge clk_in) begin
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", d_out, held_dat);
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_sample", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val($sformatf("sample_dat_%0d", acc_cnt), d_out, mon_e.dat);
          check_val($sformatf("sample_eof_%0d", acc_cnt), eof_out, mon_e.eof);
        end
        acc_cnt++;
        if (eof_out) eof_cnt++;
      end else if (out_valid) begin
        held = 1'b1;
        held_dat = d_out;
      end
      if (!out_valid && eof_out) eof_bad++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int e0;
    build_zz();

    // reset state
    tick(3);
    check_val("rst_coef_ready", coef_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_d_out", d_out, 0);
    check_val("rst_eof_out", eof_out, 0);
    rst = 1'b1;
    tick(1);
    check_val("ready_after_rst", coef_ready, 1);

    // DC-only block and first-output latency
    rdy_mode = 0;
    tick(2);
    blk_coef[0] = 10;
    send_block(1, 0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin tick(1); n++; end
    check_val("dc_latency", n, 3);
    wait_drain();

    // full block, implied last at index 63
    for (int k = 0; k < 64; k++) blk_coef[k] = k + 1;
    send_block(64, 0, 1'b0, 1'b0);
    wait_drain();

    // large products at factor_sel 3
    for (int k = 0; k < 64; k++) blk_coef[k] = 0;
    blk_coef[0]  = -5;
    blk_coef[62] = 2047;
    blk_coef[63] = -2047;
    send_block(64, 3, 1'b0, 1'b0);
    wait_drain();

    // random partial block, gaps and random downstream stalls
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) blk_coef[k] = int'($urandom_range(0, 4095)) - 2048;
    send_block(20, 1, 1'b0, 1'b1);
    wait_drain();

    // three back-to-back blocks with downstream held off
    rdy_mode = 1;
    tick(2);
    for (int k = 0; k < 64; k++) blk_coef[k] = k * 3 - 90;
    send_block(64, 2, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) blk_coef[k] = 7 - k * 11;
    send_block(10, 0, 1'b0, 1'b0);
    tick(3);
    check_val("ready_low_two_full", coef_ready, 0);
    check_val("stalled_valid", out_valid, 1);
    for (int k = 0; k < 64; k++) blk_coef[k] = 500 - k * 13;
    fork
      send_block(64, 1, 1'b0, 1'b0);
      begin
        tick(50);
        check_val("ready_still_low", coef_ready, 0);
        tick(50);
        rdy_mode = 0;
      end
    join
    wait_drain();

    // final block with eof under random stalls
    rdy_mode = 2;
    e0 = eof_cnt;
    for (int k = 0; k < 30; k++) blk_coef[k] = k * 5 - 60;
    send_block(30, 1, 1'b0, 1'b1);
    for (int k = 0; k < 64; k++) blk_coef[k] = int'($urandom_range(0, 400)) - 200;
    send_block(64, 0, 1'b1, 1'b0);
    wait_drain();
    check_val("eof_pulses", eof_cnt - e0, 1);
    check_val("eof_without_valid", eof_bad, 0);

    // reset in the middle of streaming, then a clean block
    rdy_mode = 0;
    tick(2);
    base = acc_cnt;
    for (int k = 0; k < 64; k++) blk_coef[k] = k + 100;
    send_block(64, 0, 1'b0, 1'b0);
    n = 0;
    while ((acc_cnt - base) < 30 && n < 500) begin tick(1); n++; end
    check_val("reach_sample30", (acc_cnt - base) >= 30, 1);
    @(posedge clk_in);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_val("midrst_coef_ready", coef_ready, 0);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_d_out", d_out, 0);
    check_val("midrst_eof_out", eof_out, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_val("ready_after_midrst", coef_ready, 1);
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) blk_coef[k] = int'($urandom_range(0, 1000)) - 500;
    send_block(40, 2, 1'b0, 1'b1);
    wait_drain();
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
